// File: rtl/decode_2to4_pulse.sv
// 2-to-4 one-hot decoder with a timed hold: an accepted code is shown on y for HOLD
// cycles, then a single-cycle done pulse marks normal completion.
module decode_2to4_pulse #(
  parameter int unsigned HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] x,
  output logic [3:0] y,
  output logic       busy,
  output logic       done,
  output logic [7:0] evt_cnt
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  localparam logic [7:0] HoldLast = 8'(HOLD - 1);

  state_e     state_q, state_d;
  logic [3:0] y_q, y_d;
  logic [7:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic [7:0] evt_cnt_q, evt_cnt_d;
  logic       accept;

  assign in_ready = en && (state_q == StIdle);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    evt_cnt_d = evt_cnt_q;
    unique case (state_q)
      StIdle: begin
        // Accepting here also covers the done cycle, giving one zero cycle between holds.
        if (accept) begin
          y_d       = 4'b0001 << x;
          cnt_d     = HoldLast;
          state_d   = StHold;
          evt_cnt_d = evt_cnt_q + 8'd1;
        end
      end
      StHold: begin
        if (!en) begin
          // Abort: clear the output silently, no done pulse.
          y_d     = 4'b0000;
          cnt_d   = 8'd0;
          state_d = StIdle;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          y_d     = 4'b0000;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      y_q       <= 4'b0000;
      cnt_q     <= 8'd0;
      done_q    <= 1'b0;
      evt_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      evt_cnt_q <= evt_cnt_d;
    end
  end

  assign y       = y_q;
  assign busy    = (state_q == StHold);
  assign done    = done_q;
  assign evt_cnt = evt_cnt_q;

endmodule

// File: tb/tb_decode_2to4_pulse.sv
// Directed bench for decode_2to4_pulse: a vector table on a HOLD=4 instance plus hand
// sequences for continuous streaming (HOLD=4) and 256 back-to-back accepts (HOLD=1).
module tb_decode_2to4_pulse;

  logic       clk = 1'b0;
  logic       rst, en, in_valid;
  logic [1:0] x;
  logic       rdy4, busy4, done4, rdy1, busy1, done1;
  logic [3:0] y4, y1;
  logic [7:0] evt4, evt1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_2to4_pulse #(.HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy4), .x(x),
    .y(y4), .busy(busy4), .done(done4), .evt_cnt(evt4)
  );

  decode_2to4_pulse #(.HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy1), .x(x),
    .y(y1), .busy(busy1), .done(done1), .evt_cnt(evt1)
  );

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       iv;
    logic [1:0] x;
    logic [3:0] y;
    logic       busy;
    logic       done;
    logic       rdy;
    logic [7:0] evt;
  } vec_t;

  localparam int NVec = 27;
  vec_t tbl [NVec];

  function automatic vec_t v(input logic r, input logic e, input logic iv, input logic [1:0] xx,
                             input logic [3:0] ey, input logic eb, input logic ed,
                             input logic er, input logic [7:0] ee);
    vec_t t;
    t.rst = r; t.en = e; t.iv = iv; t.x = xx;
    t.y = ey; t.busy = eb; t.done = ed; t.rdy = er; t.evt = ee;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic iv, input logic [1:0] xx);
    rst = r; en = e; in_valid = iv; x = xx;
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [3:0] ey;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 2'd0);

    // Reset, single accept of x=2 with HOLD=4
    tbl[0]  = v(1, 0, 0, 2'd0, 4'b0000, 0, 0, 0, 8'd0);
    tbl[1]  = v(0, 1, 1, 2'd2, 4'b0100, 1, 0, 0, 8'd1);
    tbl[2]  = v(0, 1, 0, 2'd0, 4'b0100, 1, 0, 0, 8'd1);
    tbl[3]  = v(0, 1, 1, 2'd3, 4'b0100, 1, 0, 0, 8'd1);  // ignored while holding
    tbl[4]  = v(0, 1, 0, 2'd0, 4'b0100, 1, 0, 0, 8'd1);
    tbl[5]  = v(0, 1, 0, 2'd0, 4'b0000, 0, 1, 1, 8'd1);
    tbl[6]  = v(0, 1, 0, 2'd0, 4'b0000, 0, 0, 1, 8'd1);
    // en low in idle with in_valid high: nothing accepted
    for (int i = 7; i < 17; i++) tbl[i] = v(0, 0, 1, 2'd1, 4'b0000, 0, 0, 0, 8'd1);
    // Accept x=3, drop en on the second hold cycle
    tbl[17] = v(0, 1, 1, 2'd3, 4'b1000, 1, 0, 0, 8'd2);
    tbl[18] = v(0, 1, 0, 2'd0, 4'b1000, 1, 0, 0, 8'd2);
    tbl[19] = v(0, 0, 1, 2'd0, 4'b0000, 0, 0, 0, 8'd2);
    tbl[20] = v(0, 0, 1, 2'd0, 4'b0000, 0, 0, 0, 8'd2);
    tbl[21] = v(0, 1, 0, 2'd0, 4'b0000, 0, 0, 1, 8'd2);
    // Accept x=1, reset on the third hold cycle
    tbl[22] = v(0, 1, 1, 2'd1, 4'b0010, 1, 0, 0, 8'd3);
    tbl[23] = v(0, 1, 0, 2'd0, 4'b0010, 1, 0, 0, 8'd3);
    tbl[24] = v(1, 1, 0, 2'd0, 4'b0000, 0, 0, 1, 8'd0);
    tbl[25] = v(0, 1, 0, 2'd0, 4'b0000, 0, 0, 1, 8'd0);
    tbl[26] = v(1, 1, 1, 2'd2, 4'b0000, 0, 0, 1, 8'd0);  // reset beats accept

    for (int i = 0; i < NVec; i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].iv, tbl[i].x);
      tick();
      check($sformatf("vec%0d {y,busy,done,rdy,evt}", i),
            32'({y4, busy4, done4, rdy4, evt4}),
            32'({tbl[i].y, tbl[i].busy, tbl[i].done, tbl[i].rdy, tbl[i].evt}));
    end

    // Continuous in_valid, x cycling every cycle, HOLD=4: period of 5 cycles
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 1'b1, 1'b1, 2'(k % 4));
      tick();
      ey = (k % 5 == 4) ? 4'b0000 : (4'b0001 << (k / 5));
      check($sformatf("stream k%0d {y,done}", k), 32'({y4, done4}),
            32'({ey, (k % 5 == 4) ? 1'b1 : 1'b0}));
    end
    check("stream evt_cnt", 32'(evt4), 32'd4);

    // HOLD=1: 256 back-to-back accepts, one-hot on even cycles only
    drive(1'b1, 1'b1, 1'b0, 2'd0);
    tick();
    check("hold1 reset {y,busy,evt}", 32'({y1, busy1, evt1}), 32'd0);
    for (int k = 0; k < 512; k++) begin
      drive(1'b0, 1'b1, 1'b1, 2'(k % 4));
      tick();
      if (k % 2 == 0)
        check($sformatf("hold1 k%0d {y,busy,done,evt}", k), 32'({y1, busy1, done1, evt1}),
              32'({4'b0001 << (k % 4), 1'b1, 1'b0, 8'((k / 2) + 1)}));
      else
        check($sformatf("hold1 k%0d {y,busy,done,evt}", k), 32'({y1, busy1, done1, evt1}),
              32'({4'b0000, 1'b0, 1'b1, 8'((k / 2) + 1)}));
      if (k == 508) check("hold1 evt before wrap", 32'(evt1), 32'd255);
    end
    check("hold1 evt wrapped", 32'(evt1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
